// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Two requesters (A = execute stage, B = branch/address unit) share one
// external combinational ALU. Round-robin grant, one transaction in flight,
// operands held on alu_* for ALU_LAT cycles before the result is captured
// into the owning requester's response registers.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    // requester A
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_op1,
    input  logic [WIDTH-1:0] a_op2,
    input  logic [2:0]       a_sel,
    output logic             a_rsp_valid,
    input  logic             a_rsp_ready,
    output logic [WIDTH-1:0] a_res,
    output logic             a_z,
    output logic             a_err,
    // requester B
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_op1,
    input  logic [WIDTH-1:0] b_op2,
    input  logic [2:0]       b_sel,
    output logic             b_rsp_valid,
    input  logic             b_rsp_ready,
    output logic [WIDTH-1:0] b_res,
    output logic             b_z,
    output logic             b_err,
    // shared ALU
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_z,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    // Capture happens on the edge where the cycle counter reaches this value.
    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    logic [1:0]       state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q,      owner_d;
    logic [3:0]       cnt_q,        cnt_d;
    logic [WIDTH-1:0] alu_op1_q,    alu_op1_d;
    logic [WIDTH-1:0] alu_op2_q,    alu_op2_d;
    logic [2:0]       alu_sel_q,    alu_sel_d;
    logic [WIDTH-1:0] a_res_q,      a_res_d;
    logic             a_z_q,        a_z_d;
    logic             a_err_q,      a_err_d;
    logic [WIDTH-1:0] b_res_q,      b_res_d;
    logic             b_z_q,        b_z_d;
    logic             b_err_q,      b_err_d;

    logic             grant;
    logic             idle;
    logic             accept;
    logic [WIDTH-1:0] req_op1;
    logic [WIDTH-1:0] req_op2;
    logic [2:0]       req_sel;
    logic             req_sel_ok;
    logic             owner_rsp_ready;

    // Round-robin grant: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        grant = GNT_A;
        if (a_valid && !b_valid) begin
            grant = GNT_A;
        end else if (b_valid && !a_valid) begin
            grant = GNT_B;
        end else if (a_valid && b_valid) begin
            grant = ~last_grant_q;
        end
    end

    // Handshake decode; ready is held low while reset is asserted so nothing is accepted then.
    always_comb begin
        idle            = (state_q == S_IDLE) && !rst;
        a_ready         = idle && a_valid && (grant == GNT_A);
        b_ready         = idle && b_valid && (grant == GNT_B);
        accept          = a_ready || b_ready;
        req_op1         = (grant == GNT_B) ? b_op1 : a_op1;
        req_op2         = (grant == GNT_B) ? b_op2 : a_op2;
        req_sel         = (grant == GNT_B) ? b_sel : a_sel;
        req_sel_ok      = (req_sel <= 3'b100);
        owner_rsp_ready = (owner_q == GNT_B) ? b_rsp_ready : a_rsp_ready;
    end

    // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_sel_d    = alu_sel_q;
        a_res_d      = a_res_q;
        a_z_d        = a_z_q;
        a_err_d      = a_err_q;
        b_res_d      = b_res_q;
        b_z_d        = b_z_q;
        b_err_d      = b_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    cnt_d        = 4'd0;
                    if (req_sel_ok) begin
                        alu_op1_d = req_op1;
                        alu_op2_d = req_op2;
                        alu_sel_d = req_sel;
                        state_d   = S_EXEC;
                    end else begin
                        // Bad op code never reaches the ALU; answer with an error straight away.
                        if (grant == GNT_B) begin
                            b_res_d = '0;
                            b_z_d   = 1'b0;
                            b_err_d = 1'b1;
                        end else begin
                            a_res_d = '0;
                            a_z_d   = 1'b0;
                            a_err_d = 1'b1;
                        end
                        state_d = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAT_M1) begin
                    if (owner_q == GNT_B) begin
                        b_res_d = alu_res;
                        b_z_d   = alu_z;
                        b_err_d = 1'b0;
                    end else begin
                        a_res_d = alu_res;
                        a_z_d   = alu_z;
                        a_err_d = 1'b0;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // Holds here for as long as the owner withholds rsp_ready.
                if (owner_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; last_grant resets to B so A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_B;
            owner_q      <= GNT_A;
            cnt_q        <= 4'd0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_sel_q    <= 3'b000;
            a_res_q      <= '0;
            a_z_q        <= 1'b0;
            a_err_q      <= 1'b0;
            b_res_q      <= '0;
            b_z_q        <= 1'b0;
            b_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_sel_q    <= alu_sel_d;
            a_res_q      <= a_res_d;
            a_z_q        <= a_z_d;
            a_err_q      <= a_err_d;
            b_res_q      <= b_res_d;
            b_z_q        <= b_z_d;
            b_err_q      <= b_err_d;
        end
    end

    // Output drive straight from registers; response valid follows RESP and the owner.
    always_comb begin
        alu_op1     = alu_op1_q;
        alu_op2     = alu_op2_q;
        alu_sel     = alu_sel_q;
        a_res       = a_res_q;
        a_z         = a_z_q;
        a_err       = a_err_q;
        b_res       = b_res_q;
        b_z         = b_z_q;
        b_err       = b_err_q;
        a_rsp_valid = (state_q == S_RESP) && (owner_q == GNT_A);
        b_rsp_valid = (state_q == S_RESP) && (owner_q == GNT_B);
        busy        = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with ALU_LAT=1 and one
// with ALU_LAT=3, sharing requester inputs but each with its own reset and
// behavioural ALU.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic        a_valid, b_valid, a_rsp_ready, b_rsp_ready;
    logic [31:0] a_op1, a_op2, b_op1, b_op2;
    logic [2:0]  a_sel, b_sel;

    logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_z, b_z, a_err, b_err, busy, alu_z;
    logic [31:0] a_res, b_res, alu_op1, alu_op2, alu_res;
    logic [2:0]  alu_sel;

    logic        x_a_ready, x_b_ready, x_a_rsp_valid, x_b_rsp_valid, x_a_z, x_b_z, x_a_err, x_b_err, x_busy, x_alu_z;
    logic [31:0] x_a_res, x_b_res, x_alu_op1, x_alu_op2, x_alu_res;
    logic [2:0]  x_alu_sel;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] o1, input logic [31:0] o2, input logic [2:0] s);
        case (s)
            3'b000:  return o1 + o2;
            3'b001:  return o1 - o2;
            3'b010:  return o1 & o2;
            3'b011:  return o1 | o2;
            3'b100:  return ($signed(o1) < $signed(o2)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res   = alu_f(alu_op1, alu_op2, alu_sel);
    assign alu_z     = (alu_res == 32'd0);
    assign x_alu_res = alu_f(x_alu_op1, x_alu_op2, x_alu_sel);
    assign x_alu_z   = (x_alu_res == 32'd0);

    alu_share_arbiter #(.WIDTH(32), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst1),
        .a_valid(a_valid), .a_ready(a_ready), .a_op1(a_op1), .a_op2(a_op2), .a_sel(a_sel),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_res(a_res), .a_z(a_z), .a_err(a_err),
        .b_valid(b_valid), .b_ready(b_ready), .b_op1(b_op1), .b_op2(b_op2), .b_sel(b_sel),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_res(b_res), .b_z(b_z), .b_err(b_err),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel), .alu_res(alu_res), .alu_z(alu_z),
        .busy(busy)
    );

    alu_share_arbiter #(.WIDTH(32), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst3),
        .a_valid(a_valid), .a_ready(x_a_ready), .a_op1(a_op1), .a_op2(a_op2), .a_sel(a_sel),
        .a_rsp_valid(x_a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_res(x_a_res), .a_z(x_a_z), .a_err(x_a_err),
        .b_valid(b_valid), .b_ready(x_b_ready), .b_op1(b_op1), .b_op2(b_op2), .b_sel(b_sel),
        .b_rsp_valid(x_b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_res(x_b_res), .b_z(x_b_z), .b_err(x_b_err),
        .alu_op1(x_alu_op1), .alu_op2(x_alu_op2), .alu_sel(x_alu_sel), .alu_res(x_alu_res), .alu_z(x_alu_z),
        .busy(x_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        a_op1 = '0; a_op2 = '0; a_sel = '0; b_op1 = '0; b_op2 = '0; b_sel = '0;
        step(); step();
        rst1 = 1'b0;
        step();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_a_rsp_valid", a_rsp_valid, 0);
        chk("rst_a_res", a_res, 0);
        chk("rst_b_err", b_err, 0);
        chk("rst_alu_op1", alu_op1, 0);
        chk("rst_alu_sel", alu_sel, 0);

        // A only: ADD 5+7
        a_valid = 1'b1; a_op1 = 32'd5; a_op2 = 32'd7; a_sel = 3'b000;
        #1;
        chk("add_a_ready", a_ready, 1);
        chk("add_b_ready", b_ready, 0);
        step();
        a_valid = 1'b0;
        chk("add_busy", busy, 1);
        chk("add_alu_op1", alu_op1, 5);
        chk("add_rsp_early", a_rsp_valid, 0);
        step();
        chk("add_rsp_valid", a_rsp_valid, 1);
        chk("add_res", a_res, 12);
        chk("add_z", a_z, 0);
        chk("add_err", a_err, 0);
        chk("add_b_rsp", b_rsp_valid, 0);
        chk("add_b_res", b_res, 0);
        step();
        chk("add_rsp_drop", a_rsp_valid, 0);
        chk("add_idle", busy, 0);
        chk("add_res_hold", a_res, 12);

        // reset pulse, then both requesters valid continuously
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        chk("rst2_a_res", a_res, 0);
        a_valid = 1'b1; a_op1 = 32'd9;    a_op2 = 32'd9;    a_sel = 3'b001;
        b_valid = 1'b1; b_op1 = 32'hF0;   b_op2 = 32'h0F;   b_sel = 3'b011;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr%0d_a_ready", i), a_ready, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_b_ready", i), b_ready, (i % 2 == 1) ? 1 : 0);
            step();
            step();
            if (i % 2 == 0) begin
                chk($sformatf("rr%0d_a_rsp", i), a_rsp_valid, 1);
                chk($sformatf("rr%0d_a_res", i), a_res, 0);
                chk($sformatf("rr%0d_a_z", i), a_z, 1);
            end else begin
                chk($sformatf("rr%0d_b_rsp", i), b_rsp_valid, 1);
                chk($sformatf("rr%0d_b_res", i), b_res, 32'hFF);
                chk($sformatf("rr%0d_b_z", i), b_z, 0);
            end
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // B SLT 3<2 with response stalled; A waits
        b_valid = 1'b1; b_op1 = 32'd3; b_op2 = 32'd2; b_sel = 3'b100;
        #1;
        chk("slt_b_ready", b_ready, 1);
        chk("slt_a_ready0", a_ready, 0);
        step();
        b_valid = 1'b0; b_rsp_ready = 1'b0;
        a_valid = 1'b1; a_op1 = 32'd1; a_op2 = 32'd1; a_sel = 3'b000;
        #1;
        chk("slt_a_blocked_exec", a_ready, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall%0d_b_rsp", i), b_rsp_valid, 1);
            chk($sformatf("stall%0d_a_ready", i), a_ready, 0);
            step();
        end
        chk("slt_b_res", b_res, 0);
        chk("slt_b_z", b_z, 1);
        b_rsp_ready = 1'b1;
        step();
        chk("slt_b_rsp_drop", b_rsp_valid, 0);
        chk("slt_a_ready_rel", a_ready, 1);
        step();
        a_valid = 1'b0;
        step();
        chk("post_a_res", a_res, 2);
        chk("post_a_z", a_z, 0);
        step();

        // invalid op code on A
        a_valid = 1'b1; a_op1 = 32'h55; a_op2 = 32'h66; a_sel = 3'b110;
        #1;
        chk("inv_a_ready", a_ready, 1);
        step();
        a_valid = 1'b0;
        chk("inv_rsp", a_rsp_valid, 1);
        chk("inv_err", a_err, 1);
        chk("inv_res", a_res, 0);
        chk("inv_z", a_z, 0);
        chk("inv_alu_sel", alu_sel, 0);
        chk("inv_alu_op1", alu_op1, 1);
        step();
        chk("inv_idle", busy, 0);
        a_valid = 1'b1; a_op1 = 32'hC; a_op2 = 32'hA; a_sel = 3'b010;
        step();
        a_valid = 1'b0;
        step();
        chk("and_res", a_res, 8);
        chk("and_err", a_err, 0);
        step();

        // ALU_LAT=3 instance
        rst1 = 1'b1;
        rst3 = 1'b0;
        a_valid = 1'b1; a_op1 = 32'h10; a_op2 = 32'h20; a_sel = 3'b000;
        #1;
        chk("l3_a_ready", x_a_ready, 1);
        step();
        a_valid = 1'b0;
        chk("l3_e1_op1", x_alu_op1, 32'h10);
        chk("l3_e1_rsp", x_a_rsp_valid, 0);
        step();
        chk("l3_e2_op1", x_alu_op1, 32'h10);
        chk("l3_e2_rsp", x_a_rsp_valid, 0);
        step();
        chk("l3_e3_op2", x_alu_op2, 32'h20);
        chk("l3_e3_rsp", x_a_rsp_valid, 0);
        step();
        chk("l3_rsp", x_a_rsp_valid, 1);
        chk("l3_res", x_a_res, 32'h30);
        step();
        chk("l3_idle", x_busy, 0);

        a_valid = 1'b1; a_op1 = 32'd3; a_op2 = 32'd4; a_sel = 3'b000;
        step();
        a_valid = 1'b0;
        step();
        chk("l3_mid_busy", x_busy, 1);
        rst3 = 1'b1;
        step();
        chk("l3r_busy", x_busy, 0);
        chk("l3r_rsp", x_a_rsp_valid, 0);
        chk("l3r_res", x_a_res, 0);
        chk("l3r_alu_op1", x_alu_op1, 0);
        chk("l3r_alu_sel", x_alu_sel, 0);
        chk("l3r_a_ready", x_a_ready, 0);
        rst3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("l3r%0d_rsp", i), x_a_rsp_valid, 0);
            chk($sformatf("l3r%0d_busy", i), x_busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
